// File: rtl/mem_atomic_arbiter_pkg.sv
// Shared types for the data-side memory arbiter: RAM handshake state,
// arbiter FSM state and the LR/SC reservation entry.
package mem_atomic_arbiter_pkg;
  localparam int WORD_W  = 32;
  localparam int RESV_LO = 2;   // reservations track word addresses

  typedef logic [WORD_W-1:0]       word_t;
  typedef logic [WORD_W-1:RESV_LO] waddr_t;

  typedef enum logic [1:0] {FREE, BUSY, ACCESS, ERROR} ramstate_t;
  typedef enum logic       {IDLE, GRANT}               arb_state_t;

  typedef struct packed {
    logic   valid;
    waddr_t waddr;
  } resv_t;
endpackage

// File: rtl/mem_atomic_arbiter_if.sv
// Requester-side and RAM-side signals of the arbiter. slave = arbiter view,
// master = the cores plus memory (testbench) view.
interface mem_atomic_arbiter_if #(parameter int NREQ = 2);
  import mem_atomic_arbiter_pkg::*;

  logic  [NREQ-1:0] req_ren;
  logic  [NREQ-1:0] req_wen;
  logic  [NREQ-1:0] req_atomic;
  word_t [NREQ-1:0] req_addr;
  word_t [NREQ-1:0] req_wdata;
  logic  [NREQ-1:0] req_wait;
  word_t            req_rdata;

  logic      ramREN;
  logic      ramWEN;
  word_t     ramaddr;
  word_t     ramstore;
  word_t     ramload;
  ramstate_t ramstate;

  modport slave (
    input  req_ren, req_wen, req_atomic, req_addr, req_wdata, ramload, ramstate,
    output req_wait, req_rdata, ramREN, ramWEN, ramaddr, ramstore
  );

  modport master (
    output req_ren, req_wen, req_atomic, req_addr, req_wdata, ramload, ramstate,
    input  req_wait, req_rdata, ramREN, ramWEN, ramaddr, ramstore
  );
endinterface

// File: rtl/mem_atomic_arbiter_rr_picker.sv
// Combinational round-robin select: first requester after 'last' wins.
module mem_atomic_arbiter_rr_picker #(
  parameter int NREQ = 2,
  parameter int IW   = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IW-1:0]   last,
  output logic [IW-1:0]   grant,
  output logic            any
);
  logic [IW-1:0] idx;

  // Scan farthest offset first so the nearest requester after 'last' overwrites.
  always_comb begin
    grant = '0;
    any   = 1'b0;
    idx   = '0;
    for (int i = NREQ; i >= 1; i--) begin
      idx = IW'((32'(last) + 32'(i)) % NREQ);
      if (req[idx]) begin
        grant = idx;
        any   = 1'b1;
      end
    end
  end
endmodule

// File: rtl/mem_atomic_arbiter.sv
// Round-robin arbiter sharing one RAM port between NREQ data-side requesters,
// owning the LR/SC reservation table. One access in flight at a time.
module mem_atomic_arbiter
  import mem_atomic_arbiter_pkg::*;
#(
  parameter int NREQ   = 2,
  parameter int ADDR_W = 32
) (
  input logic                  CLK,
  input logic                  RST,
  mem_atomic_arbiter_if.slave  bus
);
  localparam int    IW    = $clog2(NREQ);
  localparam word_t AMASK = word_t'((64'd1 << ADDR_W) - 64'd1);

  function automatic waddr_t wordof(input word_t a);
    return waddr_t'((a & AMASK) >> RESV_LO);
  endfunction

  arb_state_t         state;
  logic [IW-1:0]      owner, last, pick;
  logic               any;
  resv_t [NREQ-1:0]   resv;
  logic [NREQ-1:0]    act;

  assign act = bus.req_ren | bus.req_wen;

  mem_atomic_arbiter_rr_picker #(.NREQ(NREQ), .IW(IW)) u_pick (
    .req(act), .last(last), .grant(pick), .any(any)
  );

  // Owner's request as seen during GRANT (inputs are held stable).
  logic   o_ren, o_wen, o_at, sc, sc_ok, sc_fail, done;
  waddr_t o_wa;
  assign o_ren   = bus.req_ren[owner];
  assign o_wen   = bus.req_wen[owner];
  assign o_at    = bus.req_atomic[owner];
  assign o_wa    = wordof(bus.req_addr[owner]);
  assign sc      = o_wen & o_at;
  assign sc_ok   = resv[owner].valid && (resv[owner].waddr == o_wa);
  assign sc_fail = (state == GRANT) && sc && !sc_ok;
  assign done    = !RST && (state == GRANT) &&
                   (sc_fail || bus.ramstate == ACCESS || bus.ramstate == ERROR);

  // Winner's SC check at grant time decides whether a RAM write is issued at all.
  logic p_sc_ok;
  assign p_sc_ok = resv[pick].valid && (resv[pick].waddr == wordof(bus.req_addr[pick]));

  // Completion response: release the owner's wait and return load / SC result.
  always_comb begin
    bus.req_wait  = act;
    bus.req_rdata = '0;
    if (done) begin
      bus.req_wait[owner] = 1'b0;
      if (sc_fail)     bus.req_rdata = word_t'(1);
      else if (!o_wen) bus.req_rdata = bus.ramload;
    end
  end

  // Arbiter FSM with registered RAM request and reservation bookkeeping.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state        <= IDLE;
      owner        <= '0;
      last         <= IW'(NREQ - 1);
      resv         <= '0;
      bus.ramREN   <= 1'b0;
      bus.ramWEN   <= 1'b0;
      bus.ramaddr  <= '0;
      bus.ramstore <= '0;
    end else begin
      case (state)
        IDLE: if (any) begin
          owner        <= pick;
          state        <= GRANT;
          bus.ramaddr  <= bus.req_addr[pick];
          bus.ramstore <= bus.req_wdata[pick];
          // Write wins if both strobes are set; a doomed SC issues nothing.
          if (bus.req_wen[pick]) bus.ramWEN <= !bus.req_atomic[pick] || p_sc_ok;
          else                   bus.ramREN <= 1'b1;
        end
        GRANT: if (done) begin
          state      <= IDLE;
          last       <= owner;
          bus.ramREN <= 1'b0;
          bus.ramWEN <= 1'b0;
          if (o_ren && !o_wen && o_at) begin
            resv[owner].valid <= 1'b1;
            resv[owner].waddr <= o_wa;
          end
          if (o_wen && !sc_fail) begin
            for (int i = 0; i < NREQ; i++)
              if (resv[i].waddr == o_wa) resv[i].valid <= 1'b0;
          end
          if (sc) resv[owner].valid <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
